// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: sends a latched pattern MSB-first, repeated back-to-back.
// Optional per-repetition even-parity bit enabled by defining SERIAL_PATTERN_TX_PARITY_EN.
module serial_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);
    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t           state_reg, state_next;
    logic [PAT_W-1:0] pat_reg;
    logic [PAT_W-1:0] shift_reg;
    logic [BW-1:0]    bit_cnt_reg;
    logic [CNT_W-1:0] rep_cnt_reg;
    logic             last_bit;
    logic             last_rep;

    assign last_bit = (bit_cnt_reg == LAST_BIT);
    assign last_rep = (rep_cnt_reg == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!resetn)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:
                if (in_valid)
                    state_next = (rep_in != '0) ? SHIFT : DONE;
            SHIFT:
                if (last_bit) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    state_next = PARITY;
`else
                    if (last_rep)
                        state_next = DONE;
`endif
                end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            PARITY:
                state_next = last_rep ? DONE : SHIFT;
`endif
            DONE:
                state_next = IDLE;
            default:
                state_next = IDLE;
        endcase
    end

    // Datapath: the shift register reloads on the last bit so repetitions run with no gap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pat_reg     <= '0;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            rep_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE:
                    if (in_valid && (rep_in != '0)) begin
                        pat_reg     <= pat_in;
                        shift_reg   <= pat_in;
                        rep_cnt_reg <= rep_in;
                        bit_cnt_reg <= '0;
                    end
                SHIFT:
                    if (last_bit) begin
                        bit_cnt_reg <= '0;
                        shift_reg   <= pat_reg;
`ifndef SERIAL_PATTERN_TX_PARITY_EN
                        rep_cnt_reg <= rep_cnt_reg - CNT_W'(1);
`endif
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + BW'(1);
                        shift_reg   <= {shift_reg[PAT_W-2:0], 1'b0};
                    end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                PARITY:
                    rep_cnt_reg <= rep_cnt_reg - CNT_W'(1);
`endif
                default: ;
            endcase
        end
    end

    assign in_ready = (state_reg == IDLE);
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    assign dout_valid = (state_reg == SHIFT) || (state_reg == PARITY);
    assign dout       = (state_reg == SHIFT)  ? shift_reg[PAT_W-1] :
                        (state_reg == PARITY) ? (^pat_reg) : 1'b0;
`else
    assign dout_valid = (state_reg == SHIFT);
    assign dout       = (state_reg == SHIFT) ? shift_reg[PAT_W-1] : 1'b0;
`endif

endmodule
